// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the MMCM lock supervisor:
//   - sup_state_t : supervisor FSM states (encoding is visible on state_dbg)
//   - DEF_*       : default timing constants for a 100 MHz supervisor clock
//   - max3        : largest of three integers (counter sizing)
//   - retry_width : width of the retry counter, never below one bit
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAULT     = 3'd4
  } sup_state_t;

  // 16 cycles of MMCM reset, 1 ms lock timeout, ~10 us of stable lock.
  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 100000;
  localparam int DEF_STABLE_CYCLES       = 1024;
  localparam int DEF_MAX_RETRIES         = 4;
  localparam int DEF_SYNC_STAGES         = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // MAX_RETRIES = 0 would give a zero-width counter, so clamp to one bit.
  function automatic int retry_width(input int max_retries);
    int w;
    w = $clog2(max_retries + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/clock_lock_supervisor_sync_bits.sv
// -----------------------------------------------------------------------------
// sync_bits
// Multi-flop synchroniser for signals arriving asynchronously to clk.
// All flops reset asynchronously to 0 and carry ASYNC_REG so placement keeps
// the chain packed together.
//   clk : destination clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input
//   q   : synchronised output, STAGES clk edges behind d
// -----------------------------------------------------------------------------
module sync_bits #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_lock_supervisor.sv
// -----------------------------------------------------------------------------
// clock_lock_supervisor
// Supervises an MMCM-based pixel clock generator from the 100 MHz input clock
// domain: pulses the MMCM reset, qualifies the raw LOCKED signal as stable,
// retries failed lock attempts a bounded number of times and then parks in a
// sticky fault until restarted.
//   clk_100m    : free-running 100 MHz input clock
//   rst         : asynchronous active-high reset
//   mmcm_locked : raw MMCM LOCKED, asynchronous to clk_100m
//   req_restart : single-cycle request to clear faults and re-acquire
//   mmcm_rst    : drives MMCM RST
//   clk_locked  : qualified lock, registered
//   lock_lost   : one-cycle pulse when an established lock drops
//   fault       : sticky, retries exhausted
//   retry_count : failed attempts since last lock or restart
//   state_dbg   : current FSM state encoding
// -----------------------------------------------------------------------------
module clock_lock_supervisor
  import clock_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  localparam int RW = retry_width(MAX_RETRIES)
) (
  input  logic          clk_100m,
  input  logic          rst,
  input  logic          mmcm_locked,
  input  logic          req_restart,
  output logic          mmcm_rst,
  output logic          clk_locked,
  output logic          lock_lost,
  output logic          fault,
  output logic [RW-1:0] retry_count,
  output logic [2:0]    state_dbg
);

  // One extra bit of headroom so terminal-count compares never wrap.
  localparam int CW = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)) + 1;

  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_ONE    = RW'(1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_SAT    = '1;

  logic locked_s;

  sup_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          mmcm_rst_q, mmcm_rst_d;
  logic          clk_locked_q, clk_locked_d;
  logic          lock_lost_q, lock_lost_d;
  logic          fault_q, fault_d;
  logic          attempt_fail;
  logic [RW-1:0] retry_inc;

  sync_bits #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_lock_sync (
    .clk(clk_100m),
    .rst(rst),
    .d  (mmcm_locked),
    .q  (locked_s)
  );

  // In retry-forever mode the counter pins at all-ones instead of wrapping.
  assign retry_inc = (retry_q == RETRY_SAT) ? retry_q : (retry_q + RETRY_ONE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    lock_lost_d  = 1'b0;
    attempt_fail = 1'b0;

    // A restart overrides everything, including a lock drop on the same edge.
    if (req_restart) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        // The first high sample already counts towards qualification; with a
        // one-sample requirement it is enough to declare lock directly.
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            if (STABLE_CYCLES == 1) begin
              state_d = ST_LOCKED;
              cnt_d   = '0;
              retry_d = '0;
            end else begin
              state_d = ST_QUALIFY;
              cnt_d   = CNT_ONE;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            attempt_fail = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        // cnt_q holds the high samples seen so far; this edge adds one more.
        ST_QUALIFY: begin
          if (!locked_s) begin
            attempt_fail = 1'b1;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_LOCKED: begin
          if (!locked_s) begin
            state_d     = ST_RESET;
            cnt_d       = '0;
            lock_lost_d = 1'b1;
          end
        end

        ST_FAULT: begin
          state_d = ST_FAULT;
        end

        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase

      if (attempt_fail) begin
        retry_d = retry_inc;
        cnt_d   = '0;
        if ((MAX_RETRIES != 0) && (retry_inc == RETRY_LIMIT)) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_RESET;
        end
      end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    mmcm_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAULT);
    clk_locked_d = (state_d == ST_LOCKED);
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      retry_q      <= '0;
      mmcm_rst_q   <= 1'b1;
      clk_locked_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      mmcm_rst_q   <= mmcm_rst_d;
      clk_locked_q <= clk_locked_d;
      lock_lost_q  <= lock_lost_d;
      fault_q      <= fault_d;
    end
  end

  assign mmcm_rst    = mmcm_rst_q;
  assign clk_locked  = clk_locked_q;
  assign lock_lost   = lock_lost_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_clock_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_clock_lock_supervisor
// Self-checking bench for clock_lock_supervisor. A behavioural model tracks
// the supervisor phase from elapsed-cycle and high-run counts and is compared
// against every output after each clock edge. Directed scenarios pin exact
// edge timings with literal expectations, then a randomized phase exercises
// arbitrary LOCKED waveforms, restarts and short async resets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_lock_supervisor;

  localparam int P_RST     = 4;
  localparam int P_TIMEOUT = 50;
  localparam int P_STABLE  = 8;
  localparam int P_MAX     = 3;
  localparam int P_SYNC    = 2;
  localparam int RW        = (P_MAX == 0) ? 1 : $clog2(P_MAX + 1);
  localparam int RETRY_SAT = (1 << RW) - 1;

  localparam int PH_RESET   = 0;
  localparam int PH_WAIT    = 1;
  localparam int PH_QUALIFY = 2;
  localparam int PH_LOCKED  = 3;
  localparam int PH_FAULT   = 4;

  logic          clk_100m;
  logic          rst;
  logic          mmcm_locked;
  logic          req_restart;
  logic          mmcm_rst;
  logic          clk_locked;
  logic          lock_lost;
  logic          fault;
  logic [RW-1:0] retry_count;
  logic [2:0]    state_dbg;

  int checkCount = 0;
  int failCount  = 0;

  clock_lock_supervisor #(
    .RST_PULSE_CYCLES   (P_RST),
    .LOCK_TIMEOUT_CYCLES(P_TIMEOUT),
    .STABLE_CYCLES      (P_STABLE),
    .MAX_RETRIES        (P_MAX),
    .SYNC_STAGES        (P_SYNC)
  ) dut (
    .clk_100m   (clk_100m),
    .rst        (rst),
    .mmcm_locked(mmcm_locked),
    .req_restart(req_restart),
    .mmcm_rst   (mmcm_rst),
    .clk_locked (clk_locked),
    .lock_lost  (lock_lost),
    .fault      (fault),
    .retry_count(retry_count),
    .state_dbg  (state_dbg)
  );

  initial clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  // ---------------------------------------------------------------------------
  // Comparison helper shared by the model checker and the directed scenarios.
  // ---------------------------------------------------------------------------
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase, cycles spent in the phase, length of the current
  // run of high synchronised samples, and failed attempts.
  // ---------------------------------------------------------------------------
  int mPhase;
  int mAge;
  int mHighRun;
  int mFails;
  bit mLost;
  bit mPipe [P_SYNC];

  task automatic modelReset();
    mPhase   = PH_RESET;
    mAge     = 0;
    mHighRun = 0;
    mFails   = 0;
    mLost    = 1'b0;
    for (int i = 0; i < P_SYNC; i++) mPipe[i] = 1'b0;
  endtask

  task automatic modelFail();
    mFails = (mFails + 1 > RETRY_SAT) ? RETRY_SAT : mFails + 1;
    mAge   = 0;
    if (P_MAX != 0 && mFails == P_MAX) mPhase = PH_FAULT;
    else                               mPhase = PH_RESET;
  endtask

  task automatic modelStep(input bit raw, input bit restart);
    bit seen;
    seen = mPipe[P_SYNC-1];
    for (int i = P_SYNC - 1; i > 0; i--) mPipe[i] = mPipe[i-1];
    mPipe[0] = raw;
    mLost = 1'b0;
    if (restart) begin
      mPhase = PH_RESET;
      mAge   = 0;
      mFails = 0;
    end else begin
      case (mPhase)
        PH_RESET: begin
          mAge++;
          if (mAge == P_RST) begin
            mPhase = PH_WAIT;
            mAge   = 0;
          end
        end
        PH_WAIT: begin
          if (seen) begin
            mHighRun = 1;
            if (mHighRun == P_STABLE) begin
              mPhase = PH_LOCKED;
              mFails = 0;
            end else begin
              mPhase = PH_QUALIFY;
            end
          end else begin
            mAge++;
            if (mAge == P_TIMEOUT) modelFail();
          end
        end
        PH_QUALIFY: begin
          if (seen) begin
            mHighRun++;
            if (mHighRun == P_STABLE) begin
              mPhase = PH_LOCKED;
              mFails = 0;
            end
          end else begin
            modelFail();
          end
        end
        PH_LOCKED: begin
          if (!seen) begin
            mLost  = 1'b1;
            mPhase = PH_RESET;
            mAge   = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Model advances on each edge and outputs are compared 2 ns later.
  initial begin
    modelReset();
    forever begin
      @(posedge clk_100m);
      if (rst) modelReset();
      else     modelStep(mmcm_locked, req_restart);
      #2;
      checkOutput("mdl_state",      int'(state_dbg),   mPhase);
      checkOutput("mdl_mmcm_rst",   int'(mmcm_rst),    int'(mPhase == PH_RESET || mPhase == PH_FAULT));
      checkOutput("mdl_clk_locked", int'(clk_locked),  int'(mPhase == PH_LOCKED));
      checkOutput("mdl_fault",      int'(fault),       int'(mPhase == PH_FAULT));
      checkOutput("mdl_lock_lost",  int'(lock_lost),   int'(mLost));
      checkOutput("mdl_retry",      int'(retry_count), mFails);
    end
  end

  // Inputs change 3 ns after an edge, clear of both sampling and model checks.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk_100m);
    #3;
  endtask

  // Randomized LOCKED waveform with rare restarts and one-edge async resets.
  task automatic applyStimulus(input int cycles);
    int runLeft;
    runLeft = 0;
    for (int c = 0; c < cycles; c++) begin
      if (runLeft == 0) begin
        mmcm_locked = ~mmcm_locked;
        runLeft = mmcm_locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 25));
      end
      runLeft--;
      req_restart = ($urandom_range(0, 99) == 0);
      rst         = ($urandom_range(0, 399) == 0);
      waitEdges(1);
    end
    req_restart = 1'b0;
    rst         = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst         = 1'b1;
    mmcm_locked = 1'b0;
    req_restart = 1'b0;
    waitEdges(3);
    checkOutput("reset_mmcm_rst",   int'(mmcm_rst),    1);
    checkOutput("reset_state",      int'(state_dbg),   0);
    checkOutput("reset_clk_locked", int'(clk_locked),  0);
    checkOutput("reset_fault",      int'(fault),       0);
    checkOutput("reset_retry",      int'(retry_count), 0);

    // Scenario 1: release, lock appears 10 edges later.
    rst = 1'b0;
    waitEdges(3);
    checkOutput("s1_rst_pulse_hi", int'(mmcm_rst), 1);
    waitEdges(1);
    checkOutput("s1_rst_pulse_lo", int'(mmcm_rst), 0);
    checkOutput("s1_wait_state",   int'(state_dbg), 1);
    waitEdges(6);
    mmcm_locked = 1'b1;
    waitEdges(9);
    checkOutput("s1_not_locked_yet", int'(clk_locked), 0);
    waitEdges(1);
    checkOutput("s1_locked",       int'(clk_locked),  1);
    checkOutput("s1_retry",        int'(retry_count), 0);
    checkOutput("s1_locked_state", int'(state_dbg),   3);

    // Scenario 4: lock drops while locked.
    mmcm_locked = 1'b0;
    waitEdges(2);
    checkOutput("s4_still_locked", int'(clk_locked), 1);
    checkOutput("s4_no_lost_yet",  int'(lock_lost),  0);
    waitEdges(1);
    checkOutput("s4_unlocked",   int'(clk_locked), 0);
    checkOutput("s4_lost_pulse", int'(lock_lost),  1);
    checkOutput("s4_mmcm_rst",   int'(mmcm_rst),   1);
    waitEdges(1);
    checkOutput("s4_lost_cleared", int'(lock_lost), 0);
    waitEdges(2);
    checkOutput("s4_rst_pulse_hi", int'(mmcm_rst), 1);
    waitEdges(1);
    checkOutput("s4_rst_pulse_lo", int'(mmcm_rst),    0);
    checkOutput("s4_retry",        int'(retry_count), 0);

    // Scenario 3: lock glitches low after 5 qualify samples.
    mmcm_locked = 1'b1;
    waitEdges(5);
    mmcm_locked = 1'b0;
    waitEdges(1);
    mmcm_locked = 1'b1;
    waitEdges(1);
    checkOutput("s3_qualifying", int'(state_dbg), 2);
    waitEdges(1);
    checkOutput("s3_retry_one",   int'(retry_count), 1);
    checkOutput("s3_mmcm_rst",    int'(mmcm_rst),    1);
    checkOutput("s3_no_lock",     int'(clk_locked),  0);
    waitEdges(3);
    checkOutput("s3_rst_pulse_hi", int'(mmcm_rst), 1);
    waitEdges(1);
    checkOutput("s3_rst_pulse_lo", int'(mmcm_rst), 0);
    waitEdges(7);
    checkOutput("s3_not_locked_yet", int'(clk_locked), 0);
    waitEdges(1);
    checkOutput("s3_locked",       int'(clk_locked),  1);
    checkOutput("s3_retry_clear",  int'(retry_count), 0);

    // Scenario 2: lock gone for good, three timeouts then fault.
    mmcm_locked = 1'b0;
    waitEdges(3);
    checkOutput("s2_lost_pulse", int'(lock_lost), 1);
    waitEdges(54);
    checkOutput("s2_retry_1", int'(retry_count), 1);
    waitEdges(54);
    checkOutput("s2_retry_2", int'(retry_count), 2);
    waitEdges(53);
    checkOutput("s2_no_fault_yet", int'(fault), 0);
    waitEdges(1);
    checkOutput("s2_fault",       int'(fault),       1);
    checkOutput("s2_retry_3",     int'(retry_count), 3);
    checkOutput("s2_mmcm_rst",    int'(mmcm_rst),    1);
    checkOutput("s2_fault_state", int'(state_dbg),   4);
    waitEdges(100);
    checkOutput("s2_fault_sticky", int'(fault),      1);
    checkOutput("s2_never_locked", int'(clk_locked), 0);

    // Scenario 5: restart out of fault with lock present.
    mmcm_locked = 1'b1;
    waitEdges(5);
    checkOutput("s5_fault_holds", int'(state_dbg), 4);
    req_restart = 1'b1;
    waitEdges(1);
    req_restart = 1'b0;
    checkOutput("s5_fault_clear", int'(fault),       0);
    checkOutput("s5_retry_clear", int'(retry_count), 0);
    checkOutput("s5_state_reset", int'(state_dbg),   0);
    checkOutput("s5_mmcm_rst",    int'(mmcm_rst),    1);
    waitEdges(11);
    checkOutput("s5_not_locked_yet", int'(clk_locked), 0);
    waitEdges(1);
    checkOutput("s5_locked", int'(clk_locked), 1);

    // Scenario 6: async reset mid-qualify, then while locked.
    req_restart = 1'b1;
    waitEdges(1);
    req_restart = 1'b0;
    waitEdges(7);
    checkOutput("s6_qualifying",   int'(state_dbg), 2);
    checkOutput("s6_mmcm_rst_off", int'(mmcm_rst),  0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("s6_async_mmcm_rst", int'(mmcm_rst),   1);
    checkOutput("s6_async_unlocked", int'(clk_locked), 0);
    checkOutput("s6_async_state",    int'(state_dbg),  0);
    waitEdges(2);
    rst = 1'b0;
    waitEdges(3);
    checkOutput("s6_rst_pulse_hi", int'(mmcm_rst), 1);
    waitEdges(1);
    checkOutput("s6_rst_pulse_lo", int'(mmcm_rst), 0);
    waitEdges(7);
    checkOutput("s6_not_locked_yet", int'(clk_locked), 0);
    waitEdges(1);
    checkOutput("s6_relocked", int'(clk_locked), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("s6_async_drop_lock", int'(clk_locked), 0);
    checkOutput("s6_async_mmcm_rst2", int'(mmcm_rst),   1);
    waitEdges(1);
    rst = 1'b0;

    // Randomized phase against the model.
    mmcm_locked = 1'b0;
    applyStimulus(4000);
    waitEdges(2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
